// File: rtl/debug_step_controller.sv
// Debug command sequencer: pops command bytes from the UART receive FIFO,
// gates the pipeline advance (run / single step / halt) and reports the
// advanced-cycle counter back over the UART transmit path, LSB first.
module debug_step_controller #(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_RUN    = 8'h63,
  parameter logic [7:0]  CMD_STEP   = 8'h73,
  parameter logic [7:0]  CMD_HALT   = 8'h68,
  parameter logic [7:0]  CMD_REPORT = 8'h70
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_empty,
  output logic             rd,
  input  logic [31:0]      instr_if,
  output logic             pipe_clk_en,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_full
);

  localparam int NBYTES = CNT_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             halted_nxt;
  logic             tx_start_nxt;
  logic [7:0]       tx_data_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             at_halt;
  logic [CNT_W-1:0] count_shift;
  logic [7:0]       cur_byte;

  assign at_halt     = (instr_if == HALT_WORD);
  // Counter is frozen while in SEND, so the byte lanes stay consistent.
  assign count_shift = cycle_count >> {idx, 3'b000};
  assign cur_byte    = count_shift[7:0];

  // Pop/advance strobes and next-state decode.
  always_comb begin
    state_nxt    = state;
    halted_nxt   = halted;
    idx_nxt      = idx;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    rd           = !rx_empty && (state == IDLE || state == RUN);
    pipe_clk_en  = (state == RUN && !at_halt) || (state == STEP);
    case (state)
      IDLE: begin
        if (rd) begin
          if (rx_data == CMD_RUN) begin
            state_nxt  = RUN;
            halted_nxt = 1'b0;
          end else if (rx_data == CMD_STEP) begin
            state_nxt  = STEP;
            halted_nxt = 1'b0;
          end else if (rx_data == CMD_REPORT) begin
            state_nxt = SEND;
            idx_nxt   = '0;
          end
        end
      end
      RUN: begin
        // Halt word wins over a simultaneous halt command; the byte is
        // still consumed because rd does not depend on it.
        if (at_halt) begin
          state_nxt  = IDLE;
          halted_nxt = 1'b1;
        end else if (rd && rx_data == CMD_HALT) begin
          state_nxt = IDLE;
        end
      end
      STEP: begin
        state_nxt = IDLE;
      end
      SEND: begin
        // A pulse cycle is always followed by a gap so tx_full can update.
        if (tx_start) begin
          idx_nxt = idx + 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
          end
        end else if (!tx_full) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = cur_byte;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control and transmit registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      halted   <= 1'b0;
      idx      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      halted   <= halted_nxt;
      idx      <= idx_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
    end
  end

  // Advanced-cycle counter, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (pipe_clk_en) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_step_controller.sv
// Bench for debug_step_controller: directed scenarios plus a randomized run,
// with a queue-based receive FIFO and a behavioural reference model.
module tb_debug_step_controller;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_empty = 1'b1;
  logic        rd;
  logic [31:0] instr_if = 32'h0;
  logic        pipe_clk_en;
  logic        halted;
  logic [31:0] cycle_count;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_full = 1'b0;

  debug_step_controller dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
    .rd(rd), .instr_if(instr_if), .pipe_clk_en(pipe_clk_en), .halted(halted),
    .cycle_count(cycle_count), .tx_data(tx_data), .tx_start(tx_start),
    .tx_full(tx_full)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  logic [7:0] rxq[$];

  // Reference model: running / stepping flags and a queue of bytes to send.
  bit          m_run, m_step, m_send, m_txs, m_halted;
  logic [31:0] m_cnt;
  logic [7:0]  m_txd;
  logic [7:0]  m_txq[$];
  bit          s_rd, s_en, e_rd, e_en;

  task automatic drive_rx();
    rx_empty = (rxq.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rxq[0];
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
    drive_rx();
  endtask

  task automatic model_edge();
    logic [7:0] head;
    head = (rxq.size() > 0) ? rxq[0] : 8'h00;
    e_rd = (rxq.size() > 0) && !m_step && !m_send;
    e_en = (m_run && instr_if != HW) || m_step;
    if (m_step) begin
      m_step = 0;
    end else if (m_run) begin
      if (instr_if == HW) begin
        m_run = 0;
        m_halted = 1;
      end else if (e_rd && head == 8'h68) begin
        m_run = 0;
      end
    end else if (m_send) begin
      if (m_txs) begin
        m_txs = 0;
        if (m_txq.size() == 0) m_send = 0;
      end else if (!tx_full) begin
        m_txd = m_txq.pop_front();
        m_txs = 1;
      end
    end else if (e_rd) begin
      case (head)
        8'h63: begin m_run = 1; m_halted = 0; end
        8'h73: begin m_step = 1; m_halted = 0; end
        8'h70: begin
          m_send = 1;
          for (int i = 0; i < 4; i++) m_txq.push_back(m_cnt[8*i +: 8]);
        end
        default: ;
      endcase
    end
    if (e_en) m_cnt = m_cnt + 1;
  endtask

  // One clock: sample combinational outputs, step model, pop FIFO on rd.
  task automatic cycle();
    #1;
    s_rd = rd;
    s_en = pipe_clk_en;
    model_edge();
    @(posedge clock);
    #1;
    if (s_rd && rxq.size() > 0) rxq.delete(0);
    drive_rx();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    rxq.delete();
    drive_rx();
    instr_if = 32'h0;
    tx_full  = 1'b0;
    m_run = 0; m_step = 0; m_send = 0; m_txs = 0; m_halted = 0;
    m_cnt = 0; m_txd = 0;
    m_txq.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++; if (pipe_clk_en !== 1'b0) $display("FAIL reset_en: got %0b want 0", pipe_clk_en); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %0b want 0", halted); else passed++;
    total++; if (cycle_count !== 32'h0) $display("FAIL reset_count: got %h want 0", cycle_count); else passed++;
    total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %0b want 0", tx_start); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
    total++; if (rd !== 1'b0) $display("FAIL reset_rd: got %0b want 0", rd); else passed++;
    apply_reset();
  endtask

  task automatic test_step();
    apply_reset();
    push(8'h73);
    cycle();
    total++; if (s_rd !== 1'b1 || s_en !== 1'b0) $display("FAIL step_pop: rd=%0b en=%0b want rd=1 en=0", s_rd, s_en); else passed++;
    cycle();
    total++; if (s_en !== 1'b1 || s_rd !== 1'b0) $display("FAIL step_adv: rd=%0b en=%0b want rd=0 en=1", s_rd, s_en); else passed++;
    cycle();
    total++; if (s_en !== 1'b0) $display("FAIL step_once: en=%0b want 0", s_en); else passed++;
    total++; if (cycle_count !== 32'd1) $display("FAIL step_count: got %0d want 1", cycle_count); else passed++;
  endtask

  task automatic test_run_halt_cmd();
    int n;
    n = 0;
    apply_reset();
    push(8'h63);
    cycle();
    for (int i = 0; i < 10; i++) begin
      instr_if = $urandom & 32'h7FFF_FFFF;
      cycle();
      if (s_en) n++;
    end
    push(8'h68);
    cycle();
    if (s_en) n++;
    total++; if (s_rd !== 1'b1) $display("FAIL run_h_pop: rd=%0b want 1", s_rd); else passed++;
    cycle();
    total++; if (s_en !== 1'b0) $display("FAIL run_h_stop: en=%0b want 0", s_en); else passed++;
    total++; if (n != 11) $display("FAIL run_h_en_cycles: got %0d want 11", n); else passed++;
    total++; if (cycle_count !== 32'd11) $display("FAIL run_h_count: got %0d want 11", cycle_count); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL run_h_halted: got %0b want 0", halted); else passed++;
  endtask

  task automatic test_halt_word();
    apply_reset();
    push(8'h63);
    cycle();
    for (int i = 0; i < 5; i++) begin
      instr_if = 32'h0000_0013 + i;
      cycle();
    end
    instr_if = HW;
    #1;
    total++; if (pipe_clk_en !== 1'b0) $display("FAIL hw_comb_drop: en=%0b want 0", pipe_clk_en); else passed++;
    cycle();
    total++; if (halted !== 1'b1) $display("FAIL hw_halted: got %0b want 1", halted); else passed++;
    total++; if (cycle_count !== 32'd5) $display("FAIL hw_count: got %0d want 5", cycle_count); else passed++;
    push(8'h73);
    cycle();
    cycle();
    total++; if (s_en !== 1'b1) $display("FAIL hw_step_past: en=%0b want 1", s_en); else passed++;
    cycle();
    total++; if (cycle_count !== 32'd6) $display("FAIL hw_step_count: got %0d want 6", cycle_count); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL hw_step_clear: got %0b want 0", halted); else passed++;
  endtask

  task automatic test_report();
    logic [7:0] got[$];
    logic [7:0] want[4];
    bit prev_ts, full_applied;
    want[0] = 8'h23; want[1] = 8'h01; want[2] = 8'h00; want[3] = 8'h00;
    apply_reset();
    push(8'h63);
    cycle();
    for (int i = 0; i < 290; i++) cycle();
    push(8'h68);
    cycle();
    cycle();
    total++; if (cycle_count !== 32'h123) $display("FAIL rep_setup_count: got %h want 123", cycle_count); else passed++;
    push(8'h70);
    prev_ts = 0;
    for (int k = 0; k < 30; k++) begin
      tx_full = (k >= 4 && k < 12);
      full_applied = tx_full;
      cycle();
      total++; if (tx_start !== m_txs) $display("FAIL rep_tx_start k=%0d: got %0b want %0b", k, tx_start, m_txs); else passed++;
      if (tx_start) begin
        got.push_back(tx_data);
        total++; if (prev_ts || full_applied) $display("FAIL rep_gap_or_stall k=%0d: prev=%0b full=%0b want both 0", k, prev_ts, full_applied); else passed++;
      end
      prev_ts = tx_start;
    end
    tx_full = 1'b0;
    total++; if (got.size() != 4) $display("FAIL rep_nbytes: got %0d want 4", got.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== want[i]) $display("FAIL rep_byte%0d: got %h want %h", i, got[i], want[i]); else passed++;
      end
    end
    push(8'h73);
    cycle();
    total++; if (s_rd !== 1'b1) $display("FAIL rep_back_idle: rd=%0b want 1", s_rd); else passed++;
  endtask

  task automatic test_discard();
    apply_reset();
    push(8'h78);
    cycle();
    total++; if (s_rd !== 1'b1) $display("FAIL disc_x_pop: rd=%0b want 1", s_rd); else passed++;
    cycle();
    total++; if (s_en !== 1'b0) $display("FAIL disc_x_idle: en=%0b want 0", s_en); else passed++;
    push(8'h63);
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    push(8'h73);
    cycle();
    total++; if (s_rd !== 1'b1 || s_en !== 1'b1) $display("FAIL disc_s_run: rd=%0b en=%0b want 1 1", s_rd, s_en); else passed++;
    cycle();
    total++; if (s_en !== 1'b1) $display("FAIL disc_still_run: en=%0b want 1", s_en); else passed++;
    cycle();
    push(8'h68);
    cycle();
    cycle();
    total++; if (cycle_count !== 32'd7) $display("FAIL disc_count: got %0d want 7", cycle_count); else passed++;
  endtask

  task automatic test_reset_in_send();
    int pulses;
    pulses = 0;
    apply_reset();
    push(8'h63);
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    push(8'h68);
    cycle();
    push(8'h70);
    for (int k = 0; k < 20 && pulses < 2; k++) begin
      cycle();
      if (tx_start) pulses++;
    end
    total++; if (pulses != 2) $display("FAIL rst_send_pulses: got %0d want 2", pulses); else passed++;
    reset = 1'b1;
    #1;
    total++; if (tx_start !== 1'b0) $display("FAIL rst_send_tx_start: got %0b want 0", tx_start); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL rst_send_tx_data: got %h want 00", tx_data); else passed++;
    total++; if (cycle_count !== 32'h0) $display("FAIL rst_send_count: got %h want 0", cycle_count); else passed++;
    total++; if (pipe_clk_en !== 1'b0 || halted !== 1'b0) $display("FAIL rst_send_ctl: en=%0b halted=%0b want 0 0", pipe_clk_en, halted); else passed++;
    apply_reset();
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (tx_start) pulses++;
    end
    total++; if (pulses != 0) $display("FAIL rst_send_no_more: got %0d pulses want 0", pulses); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] b;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0 && rxq.size() < 4) begin
        case ($urandom_range(0, 5))
          0: b = 8'h63;
          1: b = 8'h73;
          2: b = 8'h68;
          3: b = 8'h70;
          4: b = 8'h78;
          default: b = 8'($urandom);
        endcase
        push(b);
      end
      instr_if = ($urandom_range(0, 9) == 0) ? HW : ($urandom & 32'h7FFF_FFFF);
      tx_full  = ($urandom_range(0, 3) == 0);
      cycle();
      total++; if (s_rd !== e_rd) $display("FAIL rnd_rd k=%0d: got %0b want %0b", k, s_rd, e_rd); else passed++;
      total++; if (s_en !== e_en) $display("FAIL rnd_en k=%0d: got %0b want %0b", k, s_en, e_en); else passed++;
      total++; if (halted !== m_halted) $display("FAIL rnd_halted k=%0d: got %0b want %0b", k, halted, m_halted); else passed++;
      total++; if (cycle_count !== m_cnt) $display("FAIL rnd_count k=%0d: got %h want %h", k, cycle_count, m_cnt); else passed++;
      total++; if (tx_start !== m_txs) $display("FAIL rnd_tx_start k=%0d: got %0b want %0b", k, tx_start, m_txs); else passed++;
      total++; if (tx_data !== m_txd) $display("FAIL rnd_tx_data k=%0d: got %h want %h", k, tx_data, m_txd); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_halt_cmd();
    test_halt_word();
    test_report();
    test_discard();
    test_reset_in_send();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
